sa_xaddr_arbiter: RTL and testbench

Slave-side address-channel arbiter. It shares one slave's AW or AR channel among MST_AMT master dispatchers using round-robin, and registers the winning request toward the slave. It records each accepted transaction's master index and length in an order FIFO, so the xDATA/WRESP arbiters can route beats in address order. It sits between the per-master xADDR dispatchers and the slave port of the interconnect.

---
 rtl/sa_xaddr_arbiter_pkg.sv | 19 +
 rtl/sa_xaddr_arbiter_fifo.sv | 57 +++++
 rtl/sa_xaddr_arbiter_rr_arbiter.sv | 35 +++
 rtl/sa_xaddr_arbiter.sv | 133 +++++++++++++
 tb/tb_sa_xaddr_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_xaddr_arbiter_pkg.sv
// Shared constants for the slave-side address-channel arbiter:
// FSM encodings, round-robin index stepping and slave-side ID construction.
package sa_xaddr_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Index reached by stepping 'off' places past 'base' among 'n' requesters.
  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

  // Slave-side ID is {master index, master-side ID}; the caller truncates to its width.
  function automatic logic [63:0] slv_id(input logic [31:0] idx, input logic [31:0] id,
                                         input int id_w);
    return (64'(idx) << id_w) | 64'(id);
  endfunction

endpackage

// File: rtl/sa_xaddr_arbiter_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head and occupancy count.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign empty   = (count == CNT_W'(0));
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sa_xaddr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request strictly after ptr, wrapping.
module rr_arbiter
  import sa_xaddr_arbiter_pkg::*;
#(
  parameter int REQ_AMT = 2,
  parameter int IDX_W   = 1
) (
  input  logic [REQ_AMT-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [REQ_AMT-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1 .. ptr+REQ_AMT so the last winner has lowest priority.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= REQ_AMT; k++) begin
      cand = IDX_W'(wrap_add(int'(ptr), k, REQ_AMT));
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sa_xaddr_arbiter.sv
// Slave-side AW/AR arbiter: round-robin among master dispatchers, registered
// request toward the slave, and an order FIFO of {master, AxLEN} for data routing.
module sa_xaddr_arbiter
  import sa_xaddr_arbiter_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
  parameter int MST_ID_W          = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AxID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AxADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]       dsp_AxBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AxLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AxSIZE_i,
  input  logic [MST_AMT-1:0]                     dsp_AxVALID_i,
  output logic [MST_AMT-1:0]                     dsp_AxREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]              s_AxID_o,
  output logic [ADDR_WIDTH-1:0]                  s_AxADDR_o,
  output logic [TRANS_BURST_W-1:0]               s_AxBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]            s_AxLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]           s_AxSIZE_o,
  output logic                                   s_AxVALID_o,
  input  logic                                   s_AxREADY_i,
  output logic [MST_ID_W-1:0]                    ord_mst_id_o,
  output logic [TRANS_DATA_LEN_W-1:0]            ord_len_o,
  output logic                                   ord_empty_o,
  input  logic                                   ord_pop_i,
  output logic [OUTST_CTN_W-1:0]                 outst_ctn_o
);

  logic [0:0]                          state;
  logic [MST_ID_W-1:0]                 rr_ptr;
  logic [MST_ID_W-1:0]                 win_idx;
  logic [MST_AMT-1:0]                  grant;
  logic                                found;
  logic                                ord_full;
  logic                                accept;
  logic [TRANS_MST_ID_W-1:0]           win_id;
  logic [ADDR_WIDTH-1:0]               win_addr;
  logic [TRANS_BURST_W-1:0]            win_burst;
  logic [TRANS_DATA_LEN_W-1:0]         win_len;
  logic [TRANS_DATA_SIZE_W-1:0]        win_size;
  logic [MST_ID_W+TRANS_DATA_LEN_W-1:0] ord_head;

  rr_arbiter #(
    .REQ_AMT (MST_AMT),
    .IDX_W   (MST_ID_W)
  ) u_rr (
    .req   (dsp_AxVALID_i),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .found (found)
  );

  // Ready depends only on local state and occupancy, never on s_AxREADY_i.
  assign accept        = (state == ST_IDLE) && found && !ord_full;
  assign dsp_AxREADY_o = accept ? grant : '0;

  assign win_id    = dsp_AxID_i[int'(win_idx)*TRANS_MST_ID_W +: TRANS_MST_ID_W];
  assign win_addr  = dsp_AxADDR_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_burst = dsp_AxBURST_i[int'(win_idx)*TRANS_BURST_W +: TRANS_BURST_W];
  assign win_len   = dsp_AxLEN_i[int'(win_idx)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
  assign win_size  = dsp_AxSIZE_i[int'(win_idx)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];

  fifo #(
    .DATA_WIDTH (MST_ID_W + TRANS_DATA_LEN_W),
    .DEPTH      (OUTSTANDING_AMT),
    .CNT_W      (OUTST_CTN_W)
  ) u_ord (
    .clk     (ACLK_i),
    .rst     (ARESET_i),
    .wr_en   (accept),
    .wr_data ({win_idx, win_len}),
    .rd_en   (ord_pop_i),
    .rd_data (ord_head),
    .empty   (ord_empty_o),
    .full    (ord_full),
    .count   (outst_ctn_o)
  );

  assign ord_mst_id_o = ord_head[TRANS_DATA_LEN_W +: MST_ID_W];
  assign ord_len_o    = ord_head[TRANS_DATA_LEN_W-1:0];

  // Request register and IDLE/SEND control; reset discards any in-flight request.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state       <= ST_IDLE;
      rr_ptr      <= MST_ID_W'(MST_AMT - 1);
      s_AxID_o    <= '0;
      s_AxADDR_o  <= '0;
      s_AxBURST_o <= '0;
      s_AxLEN_o   <= '0;
      s_AxSIZE_o  <= '0;
      s_AxVALID_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            s_AxID_o    <= TRANS_SLV_ID_W'(slv_id(32'(win_idx), 32'(win_id), TRANS_MST_ID_W));
            s_AxADDR_o  <= win_addr;
            s_AxBURST_o <= win_burst;
            s_AxLEN_o   <= win_len;
            s_AxSIZE_o  <= win_size;
            s_AxVALID_o <= 1'b1;
            rr_ptr      <= win_idx;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (s_AxREADY_i) begin
            s_AxVALID_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          s_AxVALID_o <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_xaddr_arbiter.sv
// Bench for sa_xaddr_arbiter: vector table plus hand sequences, with a request
// scoreboard and an order-FIFO scoreboard fed from a round-robin reference model.
module tb_sa_xaddr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  dsp_id;
  logic [63:0] dsp_addr;
  logic [3:0]  dsp_burst;
  logic [5:0]  dsp_len;
  logic [5:0]  dsp_size;
  logic [1:0]  dsp_valid = 2'b00;
  logic [1:0]  dsp_ready;
  logic [5:0]  s_id;
  logic [31:0] s_addr;
  logic [1:0]  s_burst;
  logic [2:0]  s_len;
  logic [2:0]  s_size;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic        ord_mst;
  logic [2:0]  ord_len;
  logic        ord_empty;
  logic        ord_pop = 1'b0;
  logic [3:0]  outst;

  logic [4:0]  id_v    [2];
  logic [31:0] addr_v  [2];
  logic [1:0]  burst_v [2];
  logic [2:0]  len_v   [2];
  logic [2:0]  size_v  [2];

  assign dsp_id    = {id_v[1], id_v[0]};
  assign dsp_addr  = {addr_v[1], addr_v[0]};
  assign dsp_burst = {burst_v[1], burst_v[0]};
  assign dsp_len   = {len_v[1], len_v[0]};
  assign dsp_size  = {size_v[1], size_v[0]};

  always #5 clk = ~clk;

  sa_xaddr_arbiter dut (
    .ACLK_i(clk), .ARESET_i(rst),
    .dsp_AxID_i(dsp_id), .dsp_AxADDR_i(dsp_addr), .dsp_AxBURST_i(dsp_burst),
    .dsp_AxLEN_i(dsp_len), .dsp_AxSIZE_i(dsp_size),
    .dsp_AxVALID_i(dsp_valid), .dsp_AxREADY_o(dsp_ready),
    .s_AxID_o(s_id), .s_AxADDR_o(s_addr), .s_AxBURST_o(s_burst),
    .s_AxLEN_o(s_len), .s_AxSIZE_o(s_size), .s_AxVALID_o(s_valid),
    .s_AxREADY_i(s_ready),
    .ord_mst_id_o(ord_mst), .ord_len_o(ord_len), .ord_empty_o(ord_empty),
    .ord_pop_i(ord_pop), .outst_ctn_o(outst)
  );

  typedef struct {
    logic [5:0]  sid;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  len;
    logic [2:0]  size;
  } req_t;

  typedef struct {
    logic       mid;
    logic [2:0] len;
  } ord_t;

  typedef struct {
    logic [1:0] v;
    logic       sr;
    logic       pp;
    logic [1:0] rdy;
    logic       sv;
    int         cnt;
  } vec_t;

  req_t sq[$];
  ord_t oq[$];
  int   m_ptr  = 1;
  int   m_cnt  = 0;
  bit   m_send = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check DUT against the model before the edge, advance model.
  task automatic step(input logic [1:0] v, input logic sr, input logic pp, input logic rs,
                      output logic [1:0] o_rdy, output logic o_sv, output int o_cnt);
    logic [1:0] exp_grant;
    int         win;
    int         c;
    dsp_valid = v;
    s_ready   = sr;
    ord_pop   = pp;
    rst       = rs;
    #1;
    check("ord_empty", ord_empty, (oq.size() == 0));
    check("outst_ctn", outst, m_cnt);
    check("s_valid", s_valid, m_send);
    if (m_send) begin
      if (sq.size() == 0) check("sb_req_avail", 0, 1);
      else begin
        check("s_id", s_id, sq[0].sid);
        check("s_addr", s_addr, sq[0].addr);
        check("s_burst", s_burst, sq[0].burst);
        check("s_len", s_len, sq[0].len);
        check("s_size", s_size, sq[0].size);
      end
    end
    win = -1;
    exp_grant = 2'b00;
    if (!m_send && v != 2'b00 && m_cnt < 8) begin
      for (int k = 1; k <= 2; k++) begin
        c = (m_ptr + k) % 2;
        if (win < 0 && v[c]) win = c;
      end
    end
    if (win >= 0) exp_grant[win] = 1'b1;
    check("dsp_ready", dsp_ready, exp_grant);
    if (pp && oq.size() > 0) begin
      check("ord_mst_id", ord_mst, oq[0].mid);
      check("ord_len", ord_len, oq[0].len);
    end
    o_rdy = dsp_ready;
    o_sv  = s_valid;
    o_cnt = int'(outst);
    @(posedge clk);
    if (rs) begin
      sq.delete();
      oq.delete();
      m_send = 1'b0;
      m_ptr  = 1;
      m_cnt  = 0;
    end else begin
      if (m_send && sr) begin
        void'(sq.pop_front());
        m_send = 1'b0;
      end
      if (pp && oq.size() > 0) begin
        void'(oq.pop_front());
        m_cnt--;
      end
      if (win >= 0) begin
        sq.push_back('{sid: {win[0], id_v[win]}, addr: addr_v[win], burst: burst_v[win],
                       len: len_v[win], size: size_v[win]});
        oq.push_back('{mid: win[0], len: len_v[win]});
        m_cnt++;
        m_ptr  = win;
        m_send = 1'b1;
      end
    end
    #1;
  endtask

  vec_t       tbl[20];
  logic [1:0] r;
  logic       sv;
  int         cn;
  int         acc;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 0};
    tbl[1]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1};
    tbl[2]  = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 0};
    tbl[4]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b1, 1};
    tbl[5]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 0};
    tbl[6]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b1, 1};
    tbl[7]  = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 0};
    tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b1, 1};
    tbl[9]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 0};
    tbl[10] = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 0};
    tbl[11] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1};
    tbl[12] = '{2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 1};
    tbl[13] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2};
    tbl[14] = '{2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 2};
    tbl[15] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2};
    tbl[16] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2};
    tbl[17] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1};
    tbl[18] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 0};
    tbl[19] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 0};

    id_v[0] = 5'd3; addr_v[0] = 32'h4000_0000; burst_v[0] = 2'd1; len_v[0] = 3'd3; size_v[0] = 3'd2;
    id_v[1] = 5'd9; addr_v[1] = 32'h8000_1000; burst_v[1] = 2'd2; len_v[1] = 3'd5; size_v[1] = 3'd3;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_valid", s_valid, 1'b0);
    check("rst_s_id", s_id, 6'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_s_len", s_len, 3'd0);
    check("rst_dsp_ready", dsp_ready, 2'b00);
    check("rst_ord_empty", ord_empty, 1'b1);
    check("rst_outst", outst, 4'd0);
    rst = 1'b0;

    // Single request, alternation under contention, FIFO push/pop corners
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].v, tbl[i].sr, tbl[i].pp, 1'b0, r, sv, cn);
      check($sformatf("vec%0d_ready", i), r, tbl[i].rdy);
      check($sformatf("vec%0d_svalid", i), sv, tbl[i].sv);
      check($sformatf("vec%0d_cnt", i), cn, tbl[i].cnt);
      if (i == 1) begin
        check("t1_s_id", s_id, 6'h03);
        check("t1_s_len", s_len, 3'd3);
        check("t1_ord_len", ord_len, 3'd3);
        check("t1_ord_mst", ord_mst, 1'b0);
      end
    end

    // Slave stall: fields must hold even though master inputs change
    step(2'b01, 1'b0, 1'b0, 1'b0, r, sv, cn);
    check("t3_accept", r, 2'b01);
    id_v[0] = 5'h1f; addr_v[0] = 32'hdead_beef; len_v[0] = 3'd7;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 1'b0, 1'b0, 1'b0, r, sv, cn);
      if (sv && r == 2'b00) acc++;
    end
    check("t3_stall_cycles", acc, 5);
    step(2'b11, 1'b1, 1'b0, 1'b0, r, sv, cn);
    step(2'b00, 1'b1, 1'b0, 1'b0, r, sv, cn);
    check("t3_idle_after", sv, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0, r, sv, cn);

    // Drain the order FIFO
    for (int i = 0; i < 12; i++) begin
      if (ord_empty) break;
      step(2'b00, 1'b1, 1'b1, 1'b0, r, sv, cn);
    end
    check("drain_empty", ord_empty, 1'b1);

    // Fill to capacity, then one pop frees a slot
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      step(2'b11, 1'b1, 1'b0, 1'b0, r, sv, cn);
      if (r != 2'b00) acc++;
    end
    check("t4_accepts", acc, 8);
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b1, 1'b0, 1'b0, r, sv, cn);
      check("t4_full_no_ready", r, 2'b00);
      check("t4_full_cnt", cn, 8);
    end
    step(2'b11, 1'b1, 1'b1, 1'b0, r, sv, cn);
    step(2'b11, 1'b1, 1'b0, 1'b0, r, sv, cn);
    check("t4_cnt_after_pop", cn, 7);
    check("t4_accept_after_pop", (r != 2'b00), 1'b1);

    // Reset while a request is in SEND
    step(2'b00, 1'b0, 1'b0, 1'b1, r, sv, cn);
    check("t6_prior_svalid", sv, 1'b1);
    check("t6_s_valid", s_valid, 1'b0);
    check("t6_outst", outst, 4'd0);
    check("t6_ord_empty", ord_empty, 1'b1);
    step(2'b11, 1'b1, 1'b0, 1'b0, r, sv, cn);
    check("t6_m0_first", r, 2'b01);
    step(2'b00, 1'b1, 1'b0, 1'b0, r, sv, cn);
    step(2'b00, 1'b1, 1'b0, 1'b0, r, sv, cn);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
